// File: rtl/spike_window_monitor_pkg.sv
// Shared defaults and record layout for the spike window monitor.
package spike_window_monitor_pkg;

    // Default widths and record FIFO depth.
    localparam int WIN_W_DEF = 8;
    localparam int CNT_W_DEF = 8;
    localparam int ISI_W_DEF = 8;
    localparam int DEPTH_DEF = 4;

    // All-ones ISI means "no completed interval in this window".
    localparam logic [ISI_W_DEF-1:0] ISI_NONE = '1;

    // One closed-window record at the default widths: {count, isi_min}.
    typedef struct packed {
        logic [CNT_W_DEF-1:0] count;
        logic [ISI_W_DEF-1:0] isi_min;
    } rec_t;

endpackage

// File: rtl/spike_window_monitor_if.sv
// Record readout handshake: the monitor drives a record, the consumer accepts it.
interface spike_window_monitor_if
    import spike_window_monitor_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int ISI_W = ISI_W_DEF
);
    logic             rec_valid;
    logic             rec_ready;
    logic [CNT_W-1:0] rec_count;
    logic [ISI_W-1:0] rec_isi_min;

    // Record source (the monitor).
    modport master (
        output rec_valid,
        output rec_count,
        output rec_isi_min,
        input  rec_ready
    );

    // Record consumer.
    modport slave (
        input  rec_valid,
        input  rec_count,
        input  rec_isi_min,
        output rec_ready
    );
endinterface

// File: rtl/spike_window_monitor_rec_fifo.sv
// First-word fall-through record FIFO with level and drop-on-full reporting.
// Storage is cleared by reset so the head reads zero while empty.
module rec_fifo
    import spike_window_monitor_pkg::*;
#(
    parameter int DATA_W = CNT_W_DEF + ISI_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_head,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;

    logic w_full;
    logic w_pop;
    logic w_push_ok;

    assign w_full    = (r_level == FULL_LVL);
    assign o_empty   = (r_level == '0);
    assign w_pop     = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign w_push_ok = i_push && (!w_full || w_pop);
    assign o_drop    = i_push && w_full && !w_pop;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    // Record storage; written at the tail on an accepted push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers (wrap naturally, DEPTH is a power of two) and fill level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/spike_window_monitor.sv
// Rate/timing readout for a spiking neuron: per programmable window it counts
// spikes and tracks the minimum inter-spike interval, then queues one record
// per closed window for a valid/ready consumer.
module spike_window_monitor
    import spike_window_monitor_pkg::*;
#(
    parameter int WIN_W = WIN_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ISI_W = ISI_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   spike_in,
    input  logic [WIN_W-1:0]       window_len,
    spike_window_monitor_if.master rec,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    input  logic                   clr_ovf
);
    localparam int REC_W = CNT_W + ISI_W;
    localparam logic [ISI_W-1:0] ISI_NO_IVL = '1;

    // Saturating increment of the spike count.
    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Saturating increment of an interval value; all-ones is sticky.
    function automatic logic [ISI_W-1:0] sat_inc_isi(input logic [ISI_W-1:0] v);
        return (v == '1) ? v : v + ISI_W'(1);
    endfunction

    function automatic logic [ISI_W-1:0] min_isi(input logic [ISI_W-1:0] a,
                                                 input logic [ISI_W-1:0] b);
        return (b < a) ? b : a;
    endfunction

    logic [WIN_W-1:0] r_win_cnt;
    logic [WIN_W-1:0] r_win_len_q;
    logic [CNT_W-1:0] r_spk_cnt;
    logic [ISI_W-1:0] r_isi_min;
    logic [ISI_W-1:0] r_isi_cnt;
    logic             r_have_prev;
    logic             r_overflow;

    logic             w_first;
    logic [WIN_W-1:0] w_len_in;
    logic [WIN_W-1:0] w_len;
    logic             w_close;
    logic             w_spike;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [ISI_W-1:0] w_ivl;
    logic [ISI_W-1:0] w_min_nxt;
    logic [REC_W-1:0] w_head;
    logic             w_empty;
    logic             w_drop;
    logic             w_pop;

    // The first cycle of a window has no latched length yet, so it looks at
    // the live input; later cycles use the length captured on that cycle.
    assign w_first  = (r_win_cnt == '0);
    assign w_len_in = (window_len == '0) ? WIN_W'(1) : window_len;
    assign w_len    = w_first ? w_len_in : r_win_len_q;
    assign w_close  = en && (r_win_cnt == (w_len - WIN_W'(1)));
    assign w_spike  = en && spike_in;

    // The closing cycle's own spike and interval belong to the record.
    assign w_cnt_nxt = w_spike ? sat_inc_cnt(r_spk_cnt) : r_spk_cnt;
    assign w_ivl     = sat_inc_isi(r_isi_cnt);
    assign w_min_nxt = (w_spike && r_have_prev) ? min_isi(r_isi_min, w_ivl) : r_isi_min;

    // Window position, captured length and per-window accumulators.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win_cnt   <= '0;
            r_win_len_q <= '0;
            r_spk_cnt   <= '0;
            r_isi_min   <= ISI_NO_IVL;
        end else if (en) begin
            if (w_first) begin
                r_win_len_q <= w_len_in;
            end
            if (w_close) begin
                r_win_cnt <= '0;
                r_spk_cnt <= '0;
                r_isi_min <= ISI_NO_IVL;
            end else begin
                r_win_cnt <= r_win_cnt + WIN_W'(1);
                r_spk_cnt <= w_cnt_nxt;
                r_isi_min <= w_min_nxt;
            end
        end
    end

    // Interval timer runs across window boundaries; it only restarts on a spike.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_isi_cnt   <= '0;
            r_have_prev <= 1'b0;
        end else if (en) begin
            if (spike_in) begin
                r_isi_cnt   <= '0;
                r_have_prev <= 1'b1;
            end else begin
                r_isi_cnt   <= sat_inc_isi(r_isi_cnt);
            end
        end
    end

    assign w_pop = !w_empty && rec.rec_ready;

    rec_fifo #(
        .DATA_W (REC_W),
        .DEPTH  (DEPTH)
    ) u_rec_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_close),
        .i_data  ({w_cnt_nxt, w_min_nxt}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_level (fifo_level),
        .o_drop  (w_drop)
    );

    // Sticky drop flag; a new drop wins over a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign overflow        = r_overflow;
    assign rec.rec_valid   = !w_empty;
    assign rec.rec_count   = w_head[ISI_W +: CNT_W];
    assign rec.rec_isi_min = w_head[ISI_W-1:0];

endmodule

// File: tb/tb_spike_window_monitor.sv
// Directed bench for spike_window_monitor: a vector table for steady-state
// windows plus hand-written sequences for FIFO, saturation, enable and reset.
module tb_spike_window_monitor;
    import spike_window_monitor_pkg::*;

    typedef struct {
        logic [7:0] wl;
        logic       spk;
        logic       rdy;
        logic       ev;
        int         ec;
        int         ei;
        int         el;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       spike_in = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] window_len = 8'd0;
    logic [2:0] fifo_level;
    logic [2:0] fifo_level4;
    logic       overflow;
    logic       overflow4;

    spike_window_monitor_if #(.CNT_W(8), .ISI_W(8)) rif ();
    spike_window_monitor_if #(.CNT_W(4), .ISI_W(8)) rif4 ();

    spike_window_monitor #(.WIN_W(8), .CNT_W(8), .ISI_W(8), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .spike_in   (spike_in),
        .window_len (window_len),
        .rec        (rif),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    spike_window_monitor #(.WIN_W(8), .CNT_W(4), .ISI_W(8), .DEPTH(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .spike_in   (spike_in),
        .window_len (window_len),
        .rec        (rif4),
        .fifo_level (fifo_level4),
        .overflow   (overflow4),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_err = 0;
    vec_t tbl[$];
    rec_t exp_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rdy(input logic r);
        rif.rec_ready  = r;
        rif4.rec_ready = r;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        en       = 1'b0;
        spike_in = 1'b0;
        clr_ovf  = 1'b0;
        set_rdy(1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_rec(input string nm, input logic ev, input int ec, input int ei, input int el);
        chk({nm, ".valid"}, int'(rif.rec_valid), int'(ev));
        chk({nm, ".count"}, int'(rif.rec_count), ec);
        chk({nm, ".isi"},   int'(rif.rec_isi_min), ei);
        chk({nm, ".level"}, int'(fifo_level), el);
    endtask

    function automatic void add(input logic [7:0] wl, input logic spk, input logic rdy,
                                input logic ev, input int ec, input int ei, input int el);
        vec_t v;
        v.wl = wl; v.spk = spk; v.rdy = rdy; v.ev = ev; v.ec = ec; v.ei = ei; v.el = el;
        tbl.push_back(v);
    endfunction

    task automatic run_tbl(input string nm, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            window_len = tbl[i].wl;
            spike_in   = tbl[i].spk;
            set_rdy(tbl[i].rdy);
            step();
            chk_rec($sformatf("%s[%0d]", nm, i - lo), tbl[i].ev, tbl[i].ec, tbl[i].ei, tbl[i].el);
        end
    endtask

    // Window pattern shared by the FIFO tests: counts 1,2,3 then empty windows.
    function automatic logic pat(input int w, input int c);
        if (w == 1) return (c == 0);
        if (w == 2) return (c < 2);
        if (w == 3) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        set_rdy(1'b0);

        // L=10, spikes on window cycles 2,5,6 -> {3,1}; popped the next cycle.
        for (int k = 0; k < 10; k++) begin
            add(8'd10, (k == 2 || k == 5 || k == 6), 1'b1, (k == 9),
                (k == 9) ? 3 : 0, (k == 9) ? 1 : 0, (k == 9) ? 1 : 0);
        end
        add(8'd10, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        // L=4, no spikes -> {0,255} every 4 cycles, level toggles 0/1.
        for (int k = 0; k < 12; k++) begin
            add(8'd4, 1'b0, 1'b1, (k % 4 == 3), 0, (k % 4 == 3) ? 255 : 0, (k % 4 == 3) ? 1 : 0);
        end

        // Reset state.
        do_reset();
        chk_rec("rst", 1'b0, 0, 0, 0);
        chk("rst.ovf", int'(overflow), 0);
        chk("rst.lvl4", int'(fifo_level4), 0);

        // Table-driven steady-state windows.
        en = 1'b1;
        run_tbl("win10", 0, 10);
        do_reset();
        en = 1'b1;
        run_tbl("win4", 11, 22);

        // Overflow: 6 windows of 3 with no consumer; clear coinciding with a drop.
        do_reset();
        window_len = 8'd3;
        en = 1'b1;
        for (int w = 1; w <= 6; w++) begin
            for (int c = 0; c < 3; c++) begin
                spike_in = pat(w, c);
                clr_ovf  = (w == 6 && c == 2);
                step();
            end
            clr_ovf = 1'b0;
            chk($sformatf("ovf.level.w%0d", w), int'(fifo_level), (w < 4) ? w : 4);
            chk($sformatf("ovf.flag.w%0d", w), int'(overflow), (w >= 5) ? 1 : 0);
            chk($sformatf("ovf.hold.w%0d", w), int'(rif.rec_count), 1);
        end
        en = 1'b0;
        spike_in = 1'b0;
        exp_q = '{'{8'd1, 8'd255}, '{8'd2, 8'd1}, '{8'd3, 8'd1}, '{8'd0, 8'd255}};
        set_rdy(1'b1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d.valid", i), int'(rif.rec_valid), 1);
            chk($sformatf("drain%0d.count", i), int'(rif.rec_count), int'(exp_q[i].count));
            chk($sformatf("drain%0d.isi", i), int'(rif.rec_isi_min), int'(exp_q[i].isi_min));
            step();
        end
        chk("drain.empty", int'(rif.rec_valid), 0);
        chk("drain.level", int'(fifo_level), 0);
        chk("drain.ovf_kept", int'(overflow), 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("clr_ovf", int'(overflow), 0);

        // Full FIFO with a pop on the close cycle: push accepted, no drop.
        do_reset();
        window_len = 8'd3;
        en = 1'b1;
        for (int w = 1; w <= 5; w++) begin
            for (int c = 0; c < 3; c++) begin
                spike_in = pat(w, c);
                set_rdy(w == 5 && c == 2);
                step();
            end
        end
        set_rdy(1'b0);
        en = 1'b0;
        spike_in = 1'b0;
        chk("fullpop.ovf", int'(overflow), 0);
        chk_rec("fullpop", 1'b1, 2, 1, 4);
        exp_q = '{'{8'd2, 8'd1}, '{8'd3, 8'd1}, '{8'd0, 8'd255}, '{8'd0, 8'd255}};
        set_rdy(1'b1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fp_drain%0d.count", i), int'(rif.rec_count), int'(exp_q[i].count));
            chk($sformatf("fp_drain%0d.isi", i), int'(rif.rec_isi_min), int'(exp_q[i].isi_min));
            step();
        end
        chk("fp_drain.empty", int'(rif.rec_valid), 0);

        // Count saturation: spike held high for a 20-cycle window.
        do_reset();
        window_len = 8'd20;
        en = 1'b1;
        set_rdy(1'b1);
        spike_in = 1'b1;
        repeat (19) step();
        chk("sat.early", int'(rif.rec_valid), 0);
        step();
        spike_in = 1'b0;
        chk_rec("sat8", 1'b1, 20, 1, 1);
        chk("sat4.valid", int'(rif4.rec_valid), 1);
        chk("sat4.count", int'(rif4.rec_count), 15);
        chk("sat4.isi", int'(rif4.rec_isi_min), 1);

        // ISI saturation: spikes 300 cycles apart across a window boundary.
        do_reset();
        window_len = 8'd200;
        en = 1'b1;
        set_rdy(1'b1);
        for (int c = 0; c < 400; c++) begin
            spike_in = (c == 0 || c == 300);
            step();
            if (c == 199) chk_rec("isisat.w1", 1'b1, 1, 255, 1);
            if (c == 399) chk_rec("isisat.w2", 1'b1, 1, 255, 1);
        end

        // en low mid-window: window stretched, spikes and length changes ignored.
        do_reset();
        window_len = 8'd5;
        set_rdy(1'b1);
        en = 1'b1; spike_in = 1'b1; step();
        window_len = 8'd2;
        en = 1'b1; spike_in = 1'b0; step();
        for (int i = 0; i < 3; i++) begin
            en = 1'b0; spike_in = 1'b1; step();
        end
        en = 1'b1; spike_in = 1'b0; step();
        step();
        chk("en.early", int'(rif.rec_valid), 0);
        spike_in = 1'b1;
        step();
        spike_in = 1'b0;
        chk_rec("en.close", 1'b1, 2, 4, 1);

        // Asynchronous reset mid-window with two records queued.
        do_reset();
        window_len = 8'd3;
        en = 1'b1;
        for (int w = 1; w <= 2; w++) begin
            for (int c = 0; c < 3; c++) begin
                spike_in = pat(w, c);
                step();
            end
        end
        spike_in = 1'b1;
        step();
        chk("pre_rst.level", int'(fifo_level), 2);
        reset = 1'b1;
        #1;
        chk_rec("async_rst", 1'b0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        window_len = 8'd4;
        en = 1'b1;
        set_rdy(1'b1);
        for (int c = 0; c < 4; c++) begin
            spike_in = (c == 1);
            step();
            if (c == 2) chk("post_rst.early", int'(rif.rec_valid), 0);
        end
        spike_in = 1'b0;
        chk_rec("post_rst", 1'b1, 1, 255, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
